// File: rtl/inst_mem_loader_if.sv
// Bundles the program-load byte stream, status outputs and the instruction
// fetch read port of inst_mem_loader.
interface inst_mem_loader_if #(
  parameter int AW = 6
);
  logic          load_start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          core_hold;
  logic          busy;
  logic          load_done;
  logic          len_err;
  logic [31:0]   checksum;

  modport master (
    output load_start, load_len, byte_valid, byte_data, rd_addr,
    input  byte_ready, rd_data, core_hold, busy, load_done, len_err, checksum
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data, rd_addr,
    output byte_ready, rd_data, core_hold, busy, load_done, len_err, checksum
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory filled from a little-endian byte stream while the core is
// held; the fetch side reads words combinationally.
module inst_mem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  inst_mem_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [AW:0] word_cnt;
  logic [AW:0] len_q;
  logic [23:0] asm_q;
  logic [31:0] checksum;
  logic        byte_ready;
  logic        busy;
  logic        load_done;
  logic        core_hold;
  logic        len_err;

  logic [31:0] mem [DEPTH];

  logic        xfer;
  logic        wr_en;
  logic [31:0] wr_word;
  logic        len_ok;

  always_comb begin
    xfer    = byte_ready && bus.byte_valid;
    wr_en   = xfer && (byte_cnt == 2'd3);
    wr_word = {bus.byte_data, asm_q};
    len_ok  = (bus.load_len != '0) && (bus.load_len <= DEPTH_L);
  end

  // Storage is never reset so a program survives a core reset; the write is
  // gated by reset so an aborted load cannot land a partial word.
  always_ff @(posedge clk) begin
    if (wr_en && reset) begin
      mem[word_cnt[AW-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      checksum   <= '0;
      len_err    <= 1'b0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
      byte_ready <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          load_done <= 1'b0;
          if (bus.load_start) begin
            if (len_ok) begin
              state      <= LOAD;
              len_err    <= 1'b0;
              byte_cnt   <= '0;
              word_cnt   <= '0;
              checksum   <= '0;
              len_q      <= bus.load_len;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              core_hold  <= 1'b1;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    asm_q[7:0]   <= bus.byte_data;
              2'd1:    asm_q[15:8]  <= bus.byte_data;
              2'd2:    asm_q[23:16] <= bus.byte_data;
              default: ;
            endcase
            if (byte_cnt == 2'd3) begin
              checksum <= checksum ^ wr_word;
              word_cnt <= word_cnt + ONE_L;
              if (word_cnt == len_q - ONE_L) begin
                state      <= DONE;
                busy       <= 1'b0;
                byte_ready <= 1'b0;
                load_done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          load_done <= 1'b0;
          core_hold <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.busy       = busy;
  assign bus.load_done  = load_done;
  assign bus.core_hold  = core_hold;
  assign bus.len_err    = len_err;
  assign bus.checksum   = checksum;
  assign bus.rd_data    = mem[bus.rd_addr];
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: reset, length errors, loads with steady
// and gapped byte streams, full-depth load and reset abort mid-load.
module tb_inst_mem_loader;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  inst_mem_loader_if #(.AW(6)) bus ();

  inst_mem_loader #(.DEPTH(64), .AW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input logic [6:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    bus.rd_addr = 6'(a);
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  initial begin
    logic [7:0] gap_bytes [4];
    gap_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    checks = 0;
    errors = 0;
    reset          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.rd_addr    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_core_hold",  32'(bus.core_hold),  32'd1);
    check("rst_load_done",  32'(bus.load_done),  32'd0);
    check("rst_len_err",    32'(bus.len_err),    32'd0);
    check("rst_checksum",   bus.checksum,        32'd0);
    reset = 1'b1;
    step();

    // Illegal lengths
    start(7'd0);
    check("len0_err",  32'(bus.len_err),   32'd1);
    check("len0_busy", 32'(bus.busy),      32'd0);
    check("len0_hold", 32'(bus.core_hold), 32'd1);
    step();
    start(7'd65);
    check("len65_err",   32'(bus.len_err),    32'd1);
    check("len65_busy",  32'(bus.busy),       32'd0);
    check("len65_ready", 32'(bus.byte_ready), 32'd0);
    check("len65_hold",  32'(bus.core_hold),  32'd1);

    // Two-word load with continuous bytes
    start(7'd2);
    check("l2_len_err", 32'(bus.len_err),    32'd0);
    check("l2_busy",    32'(bus.busy),       32'd1);
    check("l2_ready",   32'(bus.byte_ready), 32'd1);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    check("l2_done",      32'(bus.load_done),  32'd1);
    check("l2_busy_done", 32'(bus.busy),       32'd0);
    check("l2_ready_dn",  32'(bus.byte_ready), 32'd0);
    check("l2_hold_dn",   32'(bus.core_hold),  32'd1);
    check("l2_checksum",  bus.checksum,        32'h0010_0080);
    rd(0, 32'h0000_0013, "l2_mem0");
    rd(1, 32'h0010_0093, "l2_mem1");
    step();
    check("l2_done_end", 32'(bus.load_done), 32'd0);
    check("l2_hold_rel", 32'(bus.core_hold), 32'd0);
    check("l2_cks_hold", bus.checksum,       32'h0010_0080);

    // One-word load with gapped valid and an ignored load_start mid-load
    start(7'd1);
    check("g_hold", 32'(bus.core_hold), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(gap_bytes[i]);
      if (i < 3) begin
        check("g_busy_a", 32'(bus.busy), 32'd1);
        bus.byte_data = 8'h55;
        if (i == 1) begin
          bus.load_start = 1'b1;
          bus.load_len   = 7'd3;
        end
        step();
        bus.load_start = 1'b0;
        check("g_busy_b", 32'(bus.busy), 32'd1);
      end
    end
    check("g_done",     32'(bus.load_done), 32'd1);
    rd(0, 32'hDEAD_BEEF, "g_mem0");
    rd(1, 32'h0010_0093, "g_mem1_kept");
    check("g_checksum", bus.checksum, 32'hDEAD_BEEF);
    step();
    check("g_done_end", 32'(bus.load_done), 32'd0);
    check("g_no_restart", 32'(bus.busy),    32'd0);

    // Full-depth load
    start(7'd64);
    for (int i = 0; i < 64; i++) begin
      send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
    end
    check("f_done",     32'(bus.load_done), 32'd1);
    check("f_checksum", bus.checksum,       32'd0);
    rd(63, 32'h0000_003F, "f_mem63");
    rd(0,  32'h0000_0000, "f_mem0");
    rd(37, 32'h0000_0025, "f_mem37");
    step();
    check("f_hold_rel", 32'(bus.core_hold), 32'd0);

    // Reset after six bytes of a two-word load
    start(7'd2);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("ab_busy",     32'(bus.busy),       32'd0);
    check("ab_ready",    32'(bus.byte_ready), 32'd0);
    check("ab_hold",     32'(bus.core_hold),  32'd1);
    check("ab_checksum", bus.checksum,        32'd0);
    check("ab_done",     32'(bus.load_done),  32'd0);
    rd(0, 32'h4433_2211, "ab_mem0");
    rd(1, 32'h0000_0001, "ab_mem1_kept");
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    step();
    bus.byte_valid = 1'b0;
    rd(0, 32'h4433_2211, "ab_idle_ignore");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
